// File: rtl/regfile_dump_load.sv
// Sequencer on the external side of a register file: streams the register set out
// as (addr, data) beats in dump mode, or writes it from incoming beats in load mode.
module regfile_dump_load #(
  parameter int unsigned FIRST_REG       = 0,
  parameter int unsigned LAST_REG        = 31,
  parameter int unsigned SKIP_ZERO_WRITE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_addr_a,
  input  logic [31:0] rf_data_a,
  output logic [4:0]  rf_addr_in,
  output logic [31:0] rf_data_in,
  output logic        rf_write,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DUMP = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_last_issued;
  logic               r_busy;
  logic               r_done;
  logic               r_out_valid;
  logic [IDX_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]  r_out_data;

  logic w_capture;
  logic w_final_acc;
  logic w_in_acc;
  logic w_skip_write;

  // A new dump beat is captured whenever the output slot is empty or being drained.
  assign w_capture    = (r_state == S_DUMP) && !r_last_issued && (!r_out_valid || out_ready);
  assign w_final_acc  = (r_state == S_DUMP) && r_last_issued && r_out_valid && out_ready;
  assign w_in_acc     = (r_state == S_LOAD) && in_valid;
  assign w_skip_write = (SKIP_ZERO_WRITE != 0) && (r_idx == '0);

  assign busy       = r_busy;
  assign done       = r_done;
  assign rf_addr_a  = r_idx;
  assign rf_addr_in = r_idx;
  assign rf_data_in = in_data;
  assign in_ready   = (r_state == S_LOAD);
  assign rf_write   = w_in_acc && !w_skip_write;
  assign out_valid  = r_out_valid;
  assign out_addr   = r_out_addr;
  assign out_data   = r_out_data;

  // Sequencer state, index walk and registered beat/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_idx         <= FIRST_IDX;
      r_last_issued <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_addr    <= '0;
      r_out_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx         <= FIRST_IDX;
            r_last_issued <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= mode ? S_LOAD : S_DUMP;
          end
        end
        S_DUMP: begin
          if (w_final_acc) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_capture) begin
            r_out_data  <= rf_data_a;
            r_out_addr  <= r_idx;
            r_out_valid <= 1'b1;
            // Hold the index at the last register instead of wrapping.
            if (r_idx == LAST_IDX) begin
              r_last_issued <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_LOAD: begin
          if (w_in_acc) begin
            if (r_idx == LAST_IDX) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_load.sv
// Bench for regfile_dump_load: a register-file stand-in, a queue/array model of the
// expected beat stream and writes checked every cycle, and directed literal checks.
module tb_regfile_dump_load;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, mode;
  logic        busy, done;
  logic [4:0]  rf_addr_a, rf_addr_in, out_addr;
  logic [31:0] rf_data_a, rf_data_in, out_data, in_data;
  logic        rf_write, out_valid, out_ready, in_valid, in_ready;

  logic        b_start, b_busy, b_done, b_rf_write, b_out_valid, b_out_ready, b_in_ready;
  logic [4:0]  b_rf_addr_a, b_rf_addr_in, b_out_addr;
  logic [31:0] b_rf_data_a, b_rf_data_in, b_out_data;

  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] rf [32];

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [31:0] exp_rf [32];
  logic [36:0] q [$];
  logic        m_busy, m_mode, m_ov, m_done;
  int          ld_idx;
  int          n_beats, n_ld, wr_cnt, done_cnt;
  logic        wr0_seen;
  logic [4:0]  seq [32];
  logic [31:0] cap [32];

  always #5 clk = ~clk;

  regfile_dump_load u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .busy(busy), .done(done),
    .rf_addr_a(rf_addr_a), .rf_data_a(rf_data_a),
    .rf_addr_in(rf_addr_in), .rf_data_in(rf_data_in), .rf_write(rf_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  regfile_dump_load #(.FIRST_REG(4), .LAST_REG(7), .SKIP_ZERO_WRITE(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .mode(1'b0),
    .busy(b_busy), .done(b_done),
    .rf_addr_a(b_rf_addr_a), .rf_data_a(b_rf_data_a),
    .rf_addr_in(b_rf_addr_in), .rf_data_in(b_rf_data_in), .rf_write(b_rf_write),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr), .out_data(b_out_data),
    .in_valid(1'b0), .in_ready(b_in_ready), .in_data(32'h0)
  );

  // register file stand-in: combinational read, posedge write, bench preload port
  always @(posedge clk) begin
    if (rf_write) rf[rf_addr_in] <= rf_data_in;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end
  assign rf_data_a   = rf[rf_addr_a];
  assign b_rf_data_a = 32'hB000_0000 | 32'(b_rf_addr_a);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pre_val(input int i);
    case (i)
      1:       return 32'h14;
      2:       return 32'h40;
      6:       return 32'h32;
      9:       return 32'h28;
      default: return 32'h0;
    endcase
  endfunction

  // Compare DUT outputs with the model for this cycle, then advance the model
  // using the inputs that the next posedge will see.
  task automatic model_step();
    if (!reset_n) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_rf_write", 32'(rf_write), 0);
      m_busy = 1'b0; m_mode = 1'b0; m_ov = 1'b0; m_done = 1'b0;
      q.delete();
      return;
    end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("in_ready", 32'(in_ready), 32'(m_busy && m_mode));
    if (m_ov) begin
      chk("out_addr", 32'(out_addr), 32'(q[0][36:32]));
      chk("out_data", out_data, q[0][31:0]);
    end else begin
      chk("out_addr_idle", 32'(out_addr), 0);
      chk("out_data_idle", out_data, 0);
    end
    if (m_busy && m_mode && in_valid) begin
      chk("rf_addr_in", 32'(rf_addr_in), 32'(ld_idx));
      chk("rf_data_in", rf_data_in, in_data);
      chk("rf_write", 32'(rf_write), 32'(ld_idx != 0));
    end else begin
      chk("rf_write_quiet", 32'(rf_write), 0);
    end
    if (rf_write) begin
      wr_cnt++;
      if (rf_addr_in == 5'd0) wr0_seen = 1'b1;
    end
    if (done) done_cnt++;
    if (pre_we) exp_rf[pre_addr] = pre_data;

    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_mode = mode; m_ov = 1'b0;
        n_beats = 0; n_ld = 0; wr_cnt = 0; wr0_seen = 1'b0; done_cnt = 0;
        ld_idx = 0;
        q.delete();
        if (!mode) for (int i = 0; i < 32; i++) q.push_back({5'(i), exp_rf[i]});
      end
    end else if (!m_mode) begin
      if (!m_ov) begin
        m_ov = 1'b1;
      end else if (out_ready) begin
        seq[n_beats] = q[0][36:32];
        cap[q[0][36:32]] = q[0][31:0];
        n_beats++;
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_ov = 1'b0; m_busy = 1'b0; m_done = 1'b1;
        end
      end
    end else if (in_valid) begin
      if (ld_idx != 0) exp_rf[ld_idx] = in_data;
      n_ld++;
      if (ld_idx == 31) begin
        m_busy = 1'b0; m_done = 1'b1;
      end else begin
        ld_idx++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // pat 0: out_ready high; pat 1: ready 1,0,0 repeating; inject: start/mode=1 mid-dump
  task automatic run_dump(input int pat, input bit inject);
    out_ready = 1'b1;
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      out_ready = (pat == 0) || (c % 3 == 0);
      if (inject && c == 5) begin start = 1'b1; mode = 1'b1; end
      else begin start = 1'b0; mode = 1'b0; end
      tick();
      if (done) break;
    end
    start = 1'b0;
    chk("dump_done_seen", 32'(done), 1);
    tick();
  endtask

  task automatic run_load(input bit gaps);
    int  cur;
    logic acc;
    cur = 0;
    in_valid = 1'b0;
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    for (int c = 0; c < 200; c++) begin
      in_valid = !(gaps && (c % 3 == 2));
      in_data  = (gaps ? 32'h200 : 32'h100) + 32'(cur);
      acc = in_valid && in_ready;
      tick();
      if (acc) cur++;
      if (done) break;
    end
    in_valid = 1'b0;
    chk("load_done_seen", 32'(done), 1);
    tick();
  endtask

  initial begin
    int b_n, b_done_cnt, b_last_cyc, b_done_cyc;
    logic b_wr_seen;
    logic [4:0]  b_addr [8];
    logic [31:0] b_data [8];

    foreach (exp_rf[i]) exp_rf[i] = 32'h0;
    m_busy = 1'b0; m_mode = 1'b0; m_ov = 1'b0; m_done = 1'b0;
    ld_idx = 0; n_beats = 0; n_ld = 0; wr_cnt = 0; done_cnt = 0; wr0_seen = 1'b0;
    start = 1'b0; mode = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'h0;
    b_start = 1'b0; b_out_ready = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_addr", 32'(out_addr), 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_rf_write", 32'(rf_write), 0);
    chk("reset_b_busy", 32'(b_busy), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // preload r1=0x14, r2=0x40, r6=0x32, r9=0x28, rest 0
    for (int i = 0; i < 32; i++) begin
      pre_we = 1'b1; pre_addr = 5'(i); pre_data = pre_val(i);
      tick();
    end
    pre_we = 1'b0;
    tick();

    // dump at full throughput
    run_dump(0, 1'b0);
    chk("d1_beats", 32'(n_beats), 32);
    chk("d1_addr1", cap[1], 32'h14);
    chk("d1_addr2", cap[2], 32'h40);
    chk("d1_addr6", cap[6], 32'h32);
    chk("d1_addr9", cap[9], 32'h28);
    chk("d1_addr0", cap[0], 32'h0);
    chk("d1_done_cnt", 32'(done_cnt), 1);

    // dump with backpressure
    run_dump(1, 1'b0);
    chk("d2_beats", 32'(n_beats), 32);
    for (int i = 0; i < 32; i++) chk("d2_order", 32'(seq[i]), 32'(i));

    // load 0x100+idx with in_valid held high
    run_load(1'b0);
    chk("l1_beats", 32'(n_ld), 32);
    chk("l1_wr0", 32'(wr0_seen), 0);
    chk("l1_wr_cnt", 32'(wr_cnt), 31);
    chk("l1_r6", rf[6], 32'h106);
    chk("l1_r0", rf[0], 32'h0);
    run_dump(0, 1'b0);
    chk("l1_dump_r31", cap[31], 32'h11F);

    // load with valid gaps
    run_load(1'b1);
    chk("l2_beats", 32'(n_ld), 32);
    chk("l2_wr_cnt", 32'(wr_cnt), 31);
    chk("l2_r5", rf[5], 32'h205);
    run_dump(0, 1'b0);
    chk("l2_dump_r0", cap[0], 32'h0);

    // restricted-range instance: registers 4..7 only
    b_n = 0; b_done_cnt = 0; b_last_cyc = -1; b_done_cyc = -1; b_wr_seen = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (b_rf_write) b_wr_seen = 1'b1;
      if (b_done) begin b_done_cnt++; b_done_cyc = c; end
      if (b_out_valid && b_out_ready) begin
        if (b_n < 8) begin b_addr[b_n] = b_out_addr; b_data[b_n] = b_out_data; end
        b_n++;
        b_last_cyc = c;
      end
    end
    chk("b_beats", 32'(b_n), 4);
    for (int i = 0; i < 4; i++) begin
      chk("b_addr", 32'(b_addr[i]), 32'(4 + i));
      chk("b_data", b_data[i], 32'hB000_0000 | 32'(4 + i));
    end
    chk("b_done_cnt", 32'(b_done_cnt), 1);
    chk("b_done_timing", 32'(b_done_cyc), 32'(b_last_cyc + 1));
    chk("b_no_write", 32'(b_wr_seen), 0);

    // start with mode=1 while dumping is ignored
    run_dump(0, 1'b1);
    chk("ign_beats", 32'(n_beats), 32);
    chk("ign_wr_cnt", 32'(wr_cnt), 0);
    chk("ign_done_cnt", 32'(done_cnt), 1);

    // reset at beat 10 aborts the dump
    out_ready = 1'b1;
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (out_valid && out_addr == 5'd10) break;
    end
    chk("abort_at_beat10", 32'(out_addr), 10);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("abort_no_done", 32'(done_cnt), 0);
    run_dump(0, 1'b0);
    chk("rst_redump_beats", 32'(n_beats), 32);
    chk("rst_redump_first", 32'(seq[0]), 0);
    chk("rst_redump_r6", cap[6], 32'h206);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
